alu_decode_stage: RTL

- Instruction-decode pipeline stage that produces the 12-bit one-hot ALU function code, plus operand selects and the extended immediate, for the EX-stage ALU.
- Decodes the MIPS-I integer ALU subset, registers the result into the ID/EX boundary, and uses a valid/ready handshake with flush.
- Sits between the IF/ID register and the EX stage.

---
 rtl/alu_decode_stage.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/alu_decode_stage.sv
// ID stage for the MIPS-I integer ALU subset: decodes one instruction into a
// one-hot ALU function, operand selects and extended immediate, held in a
// single-entry ID/EX register with valid/ready handshake and flush.
module alu_decode_stage #(
  parameter int unsigned PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [11:0]     alu_f,
  output logic            a_sel,
  output logic [1:0]      b_sel,
  output logic [31:0]     imm_ext,
  output logic [4:0]      dst_reg,
  output logic            reg_write,
  output logic            illegal,
  output logic [PC_W-1:0] out_pc
);

  localparam logic [11:0] F_ADD  = 12'h001;
  localparam logic [11:0] F_SUB  = 12'h002;
  localparam logic [11:0] F_SLTU = 12'h004;
  localparam logic [11:0] F_SLT  = 12'h008;
  localparam logic [11:0] F_AND  = 12'h010;
  localparam logic [11:0] F_OR   = 12'h020;
  localparam logic [11:0] F_NOR  = 12'h040;
  localparam logic [11:0] F_XOR  = 12'h080;
  localparam logic [11:0] F_SLL  = 12'h100;
  localparam logic [11:0] F_SRL  = 12'h200;
  localparam logic [11:0] F_SRA  = 12'h400;
  localparam logic [11:0] F_PASB = 12'h800;

  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  state_t r_state, w_state_nxt;

  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rt, w_rd, w_shamt;
  logic [15:0] w_imm;

  logic [11:0] w_alu_f;
  logic        w_a_sel;
  logic [1:0]  w_b_sel;
  logic [31:0] w_imm_ext;
  logic [4:0]  w_dst;
  logic        w_writes;
  logic        w_illegal;
  logic        w_reg_write;
  logic        w_load;

  logic [11:0]     r_alu_f;
  logic            r_a_sel;
  logic [1:0]      r_b_sel;
  logic [31:0]     r_imm_ext;
  logic [4:0]      r_dst;
  logic            r_reg_write;
  logic            r_illegal;
  logic [PC_W-1:0] r_pc;

  assign w_op    = in_instr[31:26];
  assign w_rt    = in_instr[20:16];
  assign w_rd    = in_instr[15:11];
  assign w_shamt = in_instr[10:6];
  assign w_funct = in_instr[5:0];
  assign w_imm   = in_instr[15:0];

  always_comb begin
    w_alu_f   = '0;
    w_a_sel   = 1'b0;
    w_b_sel   = 2'd0;
    w_imm_ext = '0;
    w_dst     = '0;
    w_writes  = 1'b1;
    w_illegal = 1'b0;
    if (w_op == 6'h00) begin
      // imm_ext carries shamt so the EX B-mux can select it for immediate shifts
      w_dst     = w_rd;
      w_imm_ext = {27'd0, w_shamt};
      unique case (w_funct)
        6'h20, 6'h21: w_alu_f = F_ADD;
        6'h22, 6'h23: w_alu_f = F_SUB;
        6'h24:        w_alu_f = F_AND;
        6'h25:        w_alu_f = F_OR;
        6'h26:        w_alu_f = F_XOR;
        6'h27:        w_alu_f = F_NOR;
        6'h2A:        w_alu_f = F_SLT;
        6'h2B:        w_alu_f = F_SLTU;
        6'h00: begin w_alu_f = F_SLL; w_a_sel = 1'b1; w_b_sel = 2'd2; end
        6'h02: begin w_alu_f = F_SRL; w_a_sel = 1'b1; w_b_sel = 2'd2; end
        6'h03: begin w_alu_f = F_SRA; w_a_sel = 1'b1; w_b_sel = 2'd2; end
        6'h04: begin w_alu_f = F_SLL; w_a_sel = 1'b1; w_b_sel = 2'd3; end
        6'h06: begin w_alu_f = F_SRL; w_a_sel = 1'b1; w_b_sel = 2'd3; end
        6'h07: begin w_alu_f = F_SRA; w_a_sel = 1'b1; w_b_sel = 2'd3; end
        default: w_illegal = 1'b1;
      endcase
    end else begin
      w_dst   = w_rt;
      w_b_sel = 2'd1;
      unique case (w_op)
        6'h08, 6'h09: begin w_alu_f = F_ADD;  w_imm_ext = {{16{w_imm[15]}}, w_imm}; end
        6'h0A:        begin w_alu_f = F_SLT;  w_imm_ext = {{16{w_imm[15]}}, w_imm}; end
        6'h0B:        begin w_alu_f = F_SLTU; w_imm_ext = {{16{w_imm[15]}}, w_imm}; end
        6'h0C:        begin w_alu_f = F_AND;  w_imm_ext = {16'd0, w_imm}; end
        6'h0D:        begin w_alu_f = F_OR;   w_imm_ext = {16'd0, w_imm}; end
        6'h0E:        begin w_alu_f = F_XOR;  w_imm_ext = {16'd0, w_imm}; end
        6'h0F:        begin w_alu_f = F_PASB; w_imm_ext = {w_imm, 16'd0}; end
        6'h23:        begin w_alu_f = F_ADD;  w_imm_ext = {{16{w_imm[15]}}, w_imm}; end
        6'h2B: begin
          w_alu_f   = F_ADD;
          w_imm_ext = {{16{w_imm[15]}}, w_imm};
          w_writes  = 1'b0;
        end
        default: w_illegal = 1'b1;
      endcase
    end
    if (w_illegal) begin
      w_alu_f   = '0;
      w_a_sel   = 1'b0;
      w_b_sel   = 2'd0;
      w_imm_ext = '0;
      w_dst     = '0;
      w_writes  = 1'b0;
    end
  end

  assign w_reg_write = w_writes & (w_dst != 5'd0);

  assign in_ready = (r_state == ST_EMPTY) | out_ready;
  assign w_load   = in_valid & in_ready & ~flush;

  always_comb begin
    w_state_nxt = r_state;
    if (flush)
      w_state_nxt = ST_EMPTY;
    else if (w_load)
      w_state_nxt = ST_FULL;
    else if (out_ready)
      w_state_nxt = ST_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_EMPTY;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_f     <= '0;
      r_a_sel     <= 1'b0;
      r_b_sel     <= '0;
      r_imm_ext   <= '0;
      r_dst       <= '0;
      r_reg_write <= 1'b0;
      r_illegal   <= 1'b0;
      r_pc        <= '0;
    end else if (w_load) begin
      r_alu_f     <= w_alu_f;
      r_a_sel     <= w_a_sel;
      r_b_sel     <= w_b_sel;
      r_imm_ext   <= w_imm_ext;
      r_dst       <= w_dst;
      r_reg_write <= w_reg_write;
      r_illegal   <= w_illegal;
      r_pc        <= in_pc;
    end
  end

  assign out_valid = (r_state == ST_FULL);
  assign alu_f     = r_alu_f;
  assign a_sel     = r_a_sel;
  assign b_sel     = r_b_sel;
  assign imm_ext   = r_imm_ext;
  assign dst_reg   = r_dst;
  assign reg_write = r_reg_write;
  assign illegal   = r_illegal;
  assign out_pc    = r_pc;

endmodule
